// File: rtl/tbox_pkg.sv
// Shared encodings for the N x N, K-in-a-row board: game states, symbols,
// scan directions with their unit step, and the board FSM states.
package tbox_pkg;

    localparam logic [1:0] GS_ON   = 2'b00;
    localparam logic [1:0] GS_XWIN = 2'b01;
    localparam logic [1:0] GS_OWIN = 2'b10;
    localparam logic [1:0] GS_DRAW = 2'b11;

    localparam logic SYM_X = 1'b1;
    localparam logic SYM_O = 1'b0;

    typedef enum logic [1:0] {DIR_H, DIR_V, DIR_D, DIR_A} dir_t;
    typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DONE} state_t;

    typedef struct packed {
        logic signed [1:0] dr;
        logic signed [1:0] dc;
    } delta_t;

    // Forward unit step of each line; BACK phases walk the negated step.
    function automatic delta_t dir_delta(input dir_t d);
        delta_t v;
        case (d)
            DIR_H:   v = '{dr: 2'sd0, dc: 2'sd1};
            DIR_V:   v = '{dr: 2'sd1, dc: 2'sd0};
            DIR_D:   v = '{dr: 2'sd1, dc: 2'sd1};
            default: v = '{dr: 2'sd1, dc: -2'sd1};
        endcase
        return v;
    endfunction

endpackage

// File: rtl/tbox_line_scan.sv
// Fixed-latency line scanner: walks BACK then FWD K-1 cells from the origin in
// each of four directions, counting the same-symbol run; done pulses on the last step.
module tbox_line_scan
    import tbox_pkg::*;
#(
    parameter  int N  = 3,
    parameter  int K  = 3,
    localparam int CW = $clog2(N + 1)
) (
    input  logic            clk,
    input  logic            i_reset,
    input  logic            i_start,
    input  logic [CW-1:0]   i_org_row,
    input  logic [CW-1:0]   i_org_col,
    input  logic            i_org_sym,
    input  logic [N*N-1:0]  i_valid,
    input  logic [N*N-1:0]  i_symbol,
    output logic            o_done,
    output logic            o_hit
);

    localparam int PW = CW + 2;
    localparam int RW = $clog2(2 * K);
    localparam int SW = $clog2(K + 1);
    localparam int IW = $clog2(N * N);
    localparam logic signed [PW-1:0] P_ONE = PW'(1);
    localparam logic signed [PW-1:0] P_N   = PW'(N);

    function automatic logic signed [PW-1:0] sx(input logic [1:0] d);
        return {{(PW-2){d[1]}}, d};
    endfunction

    logic                  r_active;
    dir_t                  r_dir;
    logic                  r_fwd;
    logic [SW-1:0]         r_step;
    logic [RW-1:0]         r_run;
    logic                  r_stopped;
    logic                  r_hit;
    logic signed [PW-1:0]  r_org_row, r_org_col, r_row, r_col;
    logic                  r_org_sym;

    dir_t                  w_dir_next;
    delta_t                w_delta, w_delta_next;
    logic signed [PW-1:0]  w_dr, w_dc, w_dr_next, w_dc_next;
    logic signed [PW-1:0]  w_start_row, w_start_col;
    logic                  w_inb, w_match, w_last;
    logic [RW-1:0]         w_run_inc;
    logic [IW-1:0]         w_idx;
    int                    w_lin;

    assign w_dir_next   = dir_t'(r_dir + 2'd1);
    assign w_delta      = dir_delta(r_dir);
    assign w_delta_next = dir_delta(w_dir_next);
    assign w_dr         = sx(w_delta.dr);
    assign w_dc         = sx(w_delta.dc);
    assign w_dr_next    = sx(w_delta_next.dr);
    assign w_dc_next    = sx(w_delta_next.dc);
    assign w_start_row  = $signed({2'b00, i_org_row});
    assign w_start_col  = $signed({2'b00, i_org_col});

    assign w_inb = (r_row >= P_ONE) && (r_row <= P_N) && (r_col >= P_ONE) && (r_col <= P_N);

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        w_lin   = 0;
        w_idx   = '0;
        w_match = 1'b0;
        if (w_inb) begin
            w_lin   = (int'(r_row) - 1) * N + (int'(r_col) - 1);
            w_idx   = IW'(w_lin);
            w_match = i_valid[w_idx] && (i_symbol[w_idx] == r_org_sym);
        end
    end

    assign w_run_inc = (!r_stopped && w_match) ? r_run + RW'(1) : r_run;
    assign w_last    = (r_step == SW'(K - 1));
    assign o_done    = r_active && w_last && r_fwd && (r_dir == DIR_A);
    assign o_hit     = r_hit;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            r_active  <= 1'b0;
            r_dir     <= DIR_H;
            r_fwd     <= 1'b0;
            r_step    <= SW'(1);
            r_run     <= RW'(1);
            r_stopped <= 1'b0;
            r_hit     <= 1'b0;
            r_org_row <= '0;
            r_org_col <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_org_sym <= SYM_O;
        end else if (i_start) begin
            r_active  <= 1'b1;
            r_dir     <= DIR_H;
            r_fwd     <= 1'b0;
            r_step    <= SW'(1);
            r_run     <= RW'(1);
            r_stopped <= 1'b0;
            r_hit     <= 1'b0;
            r_org_row <= w_start_row;
            r_org_col <= w_start_col;
            r_org_sym <= i_org_sym;
            r_row     <= w_start_row - sx(dir_delta(DIR_H).dr);
            r_col     <= w_start_col - sx(dir_delta(DIR_H).dc);
        end else if (r_active) begin
            if (w_last) begin
                r_hit     <= r_hit | (w_run_inc >= RW'(K));
                r_step    <= SW'(1);
                r_stopped <= 1'b0;
                if (!r_fwd) begin
                    r_fwd <= 1'b1;
                    r_run <= w_run_inc;
                    r_row <= r_org_row + w_dr;
                    r_col <= r_org_col + w_dc;
                end else begin
                    r_fwd <= 1'b0;
                    r_run <= RW'(1);
                    r_dir <= w_dir_next;
                    r_row <= r_org_row - w_dr_next;
                    r_col <= r_org_col - w_dc_next;
                    if (r_dir == DIR_A) r_active <= 1'b0;
                end
            end else begin
                r_step    <= r_step + SW'(1);
                r_run     <= w_run_inc;
                r_stopped <= r_stopped | ~w_match;
                r_row     <= r_fwd ? r_row + w_dr : r_row - w_dr;
                r_col     <= r_fwd ? r_col + w_dc : r_col - w_dc;
            end
        end
    end

endmodule

// File: rtl/tbox_nk.sv
// N x N board with K-in-a-row detection: move acceptance, turn/move tracking
// and the IDLE/SCAN/DONE sequencing around the line scanner.
module tbox_nk
    import tbox_pkg::*;
#(
    parameter  int N   = 3,
    parameter  int K   = 3,
    localparam int CW  = $clog2(N + 1),
    localparam int MCW = $clog2(N * N + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            set,
    input  logic [CW-1:0]   row,
    input  logic [CW-1:0]   col,
    output logic [N*N-1:0]  valid,
    output logic [N*N-1:0]  symbol,
    output logic [1:0]      game_state,
    output logic            turn,
    output logic            busy,
    output logic            reject,
    output logic [MCW-1:0]  move_count
);

    localparam int IW = $clog2(N * N);

    state_t          r_state, w_state_next;
    logic [N*N-1:0]  r_valid, r_symbol;
    logic [1:0]      r_game_state;
    logic            r_turn, r_reject, r_org_sym;
    logic [MCW-1:0]  r_move_count;

    logic            w_in_range, w_occupied, w_accept;
    logic            w_scan_done, w_hit;
    logic [IW-1:0]   w_idx;
    int              w_lin;

    assign w_in_range = (row >= CW'(1)) && (row <= CW'(N)) && (col >= CW'(1)) && (col <= CW'(N));

    // Out-of-range coordinates leave the index at 0 and are masked by w_in_range.
    always_comb begin
        w_lin      = 0;
        w_idx      = '0;
        w_occupied = 1'b1;
        if (w_in_range) begin
            w_lin      = (int'(row) - 1) * N + (int'(col) - 1);
            w_idx      = IW'(w_lin);
            w_occupied = r_valid[w_idx];
        end
    end

    assign w_accept = set && (r_state == ST_IDLE) && (r_game_state == GS_ON) && w_in_range && !w_occupied;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)    w_state_next = ST_SCAN;
            ST_SCAN: if (w_scan_done) w_state_next = ST_DONE;
            ST_DONE:                  w_state_next = ST_IDLE;
            default:                  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    // NOTE: the board is a flop vector, not a RAM, so reset clears every cell.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid      <= '0;
            r_symbol     <= '0;
            r_game_state <= GS_ON;
            r_turn       <= SYM_X;
            r_reject     <= 1'b0;
            r_move_count <= '0;
            r_org_sym    <= SYM_X;
        end else begin
            r_reject <= set && !w_accept;
            if (w_accept) begin
                r_valid[w_idx]  <= 1'b1;
                r_symbol[w_idx] <= r_turn;
                r_move_count    <= r_move_count + MCW'(1);
                r_turn          <= ~r_turn;
                r_org_sym       <= r_turn;
            end
            // Win is tested before draw so a line on the last free cell still wins.
            if (r_state == ST_DONE) begin
                if (w_hit)
                    r_game_state <= (r_org_sym == SYM_O) ? GS_OWIN : GS_XWIN;
                else if (r_move_count == MCW'(N * N))
                    r_game_state <= GS_DRAW;
            end
        end
    end

    tbox_line_scan #(.N(N), .K(K)) u_scan (
        .clk       (clk),
        .i_reset   (reset),
        .i_start   (w_accept),
        .i_org_row (row),
        .i_org_col (col),
        .i_org_sym (r_turn),
        .i_valid   (r_valid),
        .i_symbol  (r_symbol),
        .o_done    (w_scan_done),
        .o_hit     (w_hit)
    );

    assign valid      = r_valid;
    assign symbol     = r_symbol;
    assign game_state = r_game_state;
    assign turn       = r_turn;
    assign busy       = (r_state != ST_IDLE);
    assign reject     = r_reject;
    assign move_count = r_move_count;

endmodule

// File: tb/tb_tbox_nk.sv
// Directed bench for tbox_nk: a 3x3/K=3 board and a 5x5/K=4 board, checking
// acceptance, refusal pulses, scan latency, win/draw outcomes and reset behaviour.
module tb_tbox_nk;

    logic       clk;
    logic       reset;

    logic       set3;
    logic [1:0] row3, col3;
    logic [8:0] valid3, symbol3;
    logic [1:0] gs3;
    logic       turn3, busy3, reject3;
    logic [3:0] mc3;

    logic        set5;
    logic [2:0]  row5, col5;
    logic [24:0] valid5, symbol5;
    logic [1:0]  gs5;
    logic        turn5, busy5, reject5;
    logic [4:0]  mc5;

    int         n_checks = 0;
    int         n_errors = 0;
    int         lat;
    logic [1:0] gsp;

    int ow_r[6] = '{1, 2, 1, 1, 3, 3};
    int ow_c[6] = '{1, 2, 3, 2, 3, 2};
    int dr_r[9] = '{1, 1, 1, 2, 2, 2, 3, 3, 3};
    int dr_c[9] = '{1, 2, 3, 1, 3, 2, 1, 3, 2};
    int xw_r[9] = '{1, 1, 2, 1, 2, 2, 3, 3, 3};
    int xw_c[9] = '{1, 2, 2, 3, 3, 1, 1, 2, 3};
    int rw_r[5] = '{3, 5, 3, 5, 3};
    int rw_c[5] = '{1, 5, 2, 4, 3};
    int ad_r[7] = '{5, 1, 4, 1, 3, 1, 2};
    int ad_c[7] = '{2, 1, 3, 2, 4, 3, 5};

    tbox_nk #(.N(3), .K(3)) u_dut3 (
        .clk(clk), .reset(reset), .set(set3), .row(row3), .col(col3),
        .valid(valid3), .symbol(symbol3), .game_state(gs3), .turn(turn3),
        .busy(busy3), .reject(reject3), .move_count(mc3)
    );

    tbox_nk #(.N(5), .K(4)) u_dut5 (
        .clk(clk), .reset(reset), .set(set5), .row(row5), .col(col5),
        .valid(valid5), .symbol(symbol5), .game_state(gs5), .turn(turn5),
        .busy(busy5), .reject(reject5), .move_count(mc5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set3 = 1'b0; row3 = '0; col3 = '0;
        set5 = 1'b0; row5 = '0; col5 = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_reset3(input string tag);
        check({tag, "_valid"},  valid3,  9'h000);
        check({tag, "_symbol"}, symbol3, 9'h000);
        check({tag, "_gs"},     gs3,     2'b00);
        check({tag, "_turn"},   turn3,   1'b1);
        check({tag, "_busy"},   busy3,   1'b0);
        check({tag, "_reject"}, reject3, 1'b0);
        check({tag, "_mc"},     mc3,     4'd0);
    endtask

    // One move on the 3x3 board: returns busy cycles and the state seen on the last busy cycle.
    task automatic move3(input int r, input int c, output int cyc, output logic [1:0] gs_pre);
        row3 = 2'(r); col3 = 2'(c); set3 = 1'b1;
        @(negedge clk);
        set3 = 1'b0;
        cyc = 0;
        gs_pre = gs3;
        while (busy3 === 1'b1 && cyc < 200) begin
            cyc++;
            gs_pre = gs3;
            @(negedge clk);
        end
    endtask

    task automatic move5(input int r, input int c, output int cyc, output logic [1:0] gs_pre);
        row5 = 3'(r); col5 = 3'(c); set5 = 1'b1;
        @(negedge clk);
        set5 = 1'b0;
        cyc = 0;
        gs_pre = gs5;
        while (busy5 === 1'b1 && cyc < 200) begin
            cyc++;
            gs_pre = gs5;
            @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b1;
        set3 = 1'b0; row3 = '0; col3 = '0;
        set5 = 1'b0; row5 = '0; col5 = '0;

        do_reset();
        check_reset3("rst0");
        check("rst0_gs5",   gs5,    2'b00);
        check("rst0_turn5", turn5,  1'b1);
        check("rst0_val5",  valid5, 25'h0);

        // Refusals: set held through the scan with duplicate, row 0 and (1,3).
        row3 = 2'd1; col3 = 2'd1; set3 = 1'b1;
        @(negedge clk);
        check("ref_acc_reject", reject3, 1'b0);
        check("ref_acc_busy",   busy3,   1'b1);
        @(negedge clk);
        check("ref_dup_busy",   reject3, 1'b1);
        row3 = 2'd0;
        @(negedge clk);
        check("ref_row0_busy",  reject3, 1'b1);
        row3 = 2'd1; col3 = 2'd3;
        @(negedge clk);
        check("ref_13_busy",    reject3, 1'b1);
        set3 = 1'b0;
        @(negedge clk);
        check("ref_pulse_end",  reject3, 1'b0);
        lat = 0;
        while (busy3 === 1'b1 && lat < 200) begin
            lat++;
            @(negedge clk);
        end
        check("ref_scan_end", busy3, 1'b0);
        row3 = 2'd1; col3 = 2'd1; set3 = 1'b1;
        @(negedge clk);
        set3 = 1'b0;
        check("ref_dup_idle", reject3, 1'b1);
        @(negedge clk);
        check("ref_dup_one",  reject3, 1'b0);
        row3 = 2'd0; col3 = 2'd1; set3 = 1'b1;
        @(negedge clk);
        set3 = 1'b0;
        check("ref_row0_idle", reject3, 1'b1);
        @(negedge clk);
        check("ref_row0_one",  reject3, 1'b0);
        check("ref_valid",  valid3,  9'h001);
        check("ref_symbol", symbol3, 9'h001);
        check("ref_turn",   turn3,   1'b0);
        check("ref_mc",     mc3,     4'd1);
        check("ref_gs",     gs3,     2'b00);

        // O wins down column 2 on the sixth move.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            move3(ow_r[i], ow_c[i], lat, gsp);
            check("ow_latency", lat, 17);
            check("ow_gs_pre",  gsp, 2'b00);
            check("ow_gs",      gs3, (i == 5) ? 2'b10 : 2'b00);
        end
        check("ow_valid",  valid3,  9'h197);
        check("ow_symbol", symbol3, 9'h105);
        check("ow_turn",   turn3,   1'b1);
        check("ow_mc",     mc3,     4'd6);

        // Move after the win is refused and the board stays frozen.
        row3 = 2'd3; col3 = 2'd1; set3 = 1'b1;
        @(negedge clk);
        set3 = 1'b0;
        check("post_win_reject", reject3, 1'b1);
        @(negedge clk);
        check("post_win_valid",  valid3,  9'h197);
        check("post_win_symbol", symbol3, 9'h105);
        check("post_win_gs",     gs3,     2'b10);
        check("post_win_mc",     mc3,     4'd6);
        check("post_win_busy",   busy3,   1'b0);

        // Full board with no line: draw.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            move3(dr_r[i], dr_c[i], lat, gsp);
            check("draw_latency", lat, 17);
            check("draw_gs", gs3, (i == 8) ? 2'b11 : 2'b00);
        end
        check("draw_mc",     mc3,     4'd9);
        check("draw_valid",  valid3,  9'h1FF);
        check("draw_symbol", symbol3, 9'h0E5);

        // Ninth move completes the X diagonal: win beats draw.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            move3(xw_r[i], xw_c[i], lat, gsp);
            check("xlast_gs", gs3, (i == 8) ? 2'b01 : 2'b00);
        end
        check("xlast_mc", mc3, 4'd9);

        // Reset five cycles into a scan, with set asserted alongside reset.
        do_reset();
        row3 = 2'd1; col3 = 2'd1; set3 = 1'b1;
        @(negedge clk);
        set3 = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_busy", busy3, 1'b1);
        reset = 1'b1;
        row3 = 2'd2; col3 = 2'd2; set3 = 1'b1;
        #1;
        check("mid_async_busy",  busy3,  1'b0);
        check("mid_async_valid", valid3, 9'h000);
        @(negedge clk);
        check_reset3("mid_rst_set");
        reset = 1'b0;
        set3 = 1'b0;
        repeat (25) @(negedge clk);
        check_reset3("mid_after");
        move3(2, 2, lat, gsp);
        check("mid_new_latency", lat,     17);
        check("mid_new_valid",   valid3,  9'h010);
        check("mid_new_symbol",  symbol3, 9'h010);
        check("mid_new_turn",    turn3,   1'b0);

        // 5x5, K=4: a 3-long X row is not a win.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            move5(rw_r[i], rw_c[i], lat, gsp);
            check("n5_row_latency", lat, 25);
            check("n5_row_gs",      gs5, 2'b00);
        end
        check("n5_row_mc", mc5, 5'd5);

        // 5x5, K=4: X completes the anti-diagonal at its top-right end.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            move5(ad_r[i], ad_c[i], lat, gsp);
            check("n5_ad_latency", lat, 25);
            check("n5_ad_gs_pre",  gsp, 2'b00);
            check("n5_ad_gs",      gs5, (i == 6) ? 2'b01 : 2'b00);
        end
        check("n5_ad_mc",   mc5,   5'd7);
        check("n5_ad_turn", turn5, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/tbox_nk.md
Name: tbox_nk

Overview:
- Parametrised successor to the 3x3 tic-tac-toe board block: N x N board, K-in-a-row win, same 1-based row/col coding and game_state encoding.
- Win detection is a sequential line scanner walking outward from the last-placed cell, so any N/K fits without an O(N^2·K) combinational tree.
- Sits between the move-entry front end and the board display; exposes busy/reject so the front end paces moves.

Parameters:
- N, 3, board side length (3..15).
- K, 3, run length needed to win (2..N).
- CW, $clog2(N+1), row/col width (localparam).
- MCW, $clog2(N*N+1), move-counter width (localparam).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears the board and game.
- set  in  1  move request, sampled on each rising edge.
- row  in  CW  1-based row; 0 or >N is invalid.
- col  in  CW  1-based column; 0 or >N is invalid.
- valid  out  N*N  cell occupied; index (row-1)*N+(col-1).
- symbol  out  N*N  cell owner, 1=X, 0=O; 0 where valid=0.
- game_state  out  2  00 on, 01 X won, 10 O won, 11 draw.
- turn  out  1  next mover, 1=X.
- busy  out  1  scan in progress; moves refused.
- reject  out  1  one-cycle pulse: set seen but move refused.
- move_count  out  MCW  accepted moves since reset.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high.
- Reset values: valid=0, symbol=0, game_state=00, turn=1 (X first), busy=0, reject=0, move_count=0, FSM=IDLE. Reset mid-scan aborts the scan with no state update. Reset wins over a simultaneous set.
- Acceptance: a move is accepted on an edge where set=1 and all of these hold: FSM=IDLE, game_state=00, 1<=row<=N, 1<=col<=N, cell empty.
  - On that edge: valid[i]<=1, symbol[i]<=turn, move_count++, turn toggles. Origin (row, col, symbol) is latched. FSM goes to SCAN and busy<=1.
- Refusal: set=1 that fails any acceptance condition causes no state change, and reject=1 for the following cycle only. set=0 never rejects.
- SCAN walks 4 directions in order H, V, diag, anti-diag. Each direction has a BACK phase, then a FWD phase, each exactly K-1 cycles: 8*(K-1) cycles total, fixed.
  - Per direction: run=1. Each step moves one cell further from the origin.
  - If the cell is in-bounds, valid, same symbol, and that phase is not yet stopped, run++. Otherwise the phase stops, but cycles keep elapsing so latency stays fixed.
  - Phase ends with hit |= (run>=K).
- DONE takes 1 cycle.
  - hit: game_state<=01 if the origin symbol is X, else 10.
  - else if move_count==N*N: game_state<=11.
  - Win beats draw on the final move.
  - busy<=0 and FSM returns to IDLE.
- Latency: game_state is valid 8*(K-1)+1 edges after the accepting edge; busy falls on that same edge. For N=K=3 that is 17 cycles.
- After game_state!=00 every set is refused (reject pulses) and the board is frozen until reset.
- set held high during the scan: reject pulses every cycle while busy.
- Out-of-range coordinates never index the board.

Decomposition:
- Package tbox_pkg:
  - GS_ON=2'b00, GS_XWIN=2'b01, GS_OWIN=2'b10, GS_DRAW=2'b11.
  - SYM_X=1'b1, SYM_O=1'b0.
  - Direction enum DIR_H/DIR_V/DIR_D/DIR_A, with signed step deltas (dr,dc) per direction.
- Sub-module tbox_line_scan (parameters N, K):
  - Inputs: start pulse, origin row/col/symbol, valid, symbol.
  - Contains the direction/phase/step counters and run counter.
  - Outputs: done pulse and hit.
- The top holds the board registers, turn, move_count, acceptance/reject logic and the IDLE/SCAN/DONE FSM.

Test Plan:
- N=K=3, moves (1,1)X (2,2)O (1,3)X (1,2)O (3,3)X (3,2)O, waiting for busy=0 between moves -> game_state=10 exactly 17 cycles after the 6th accept; busy high for those 17 cycles.
- N=K=3 draw, 9 alternating moves X(1,1) O(1,2) X(1,3) O(2,1) X(2,3) O(2,2) X(3,1) O(3,3) X(3,2) -> game_state=11, move_count=9. Separately, a 9th move that completes an X line -> 01, not 11.
- N=K=3 refusals: (1,1) twice, then (0,1), then (1,3), each with set also held through the scan -> reject=1 one cycle each, valid=9'b000000001 unchanged, turn=0.
- N=5, K=4: X at (5,2),(4,3),(3,4),(2,5) on the anti-diagonal, O moves elsewhere -> game_state=01, 25 cycles after the 4th X accept. A 3-long X row -> stays 00.
- Win then move: after the O win, set at (3,1) -> reject=1, board and game_state=10 unchanged.
- Reset: assert reset 5 cycles into a scan, plus set and reset together -> all outputs at reset values, FSM=IDLE, no stale game_state update afterwards.
